// File: rtl/ccd_reg_write_arbiter_pkg.sv
// Shared definitions for the CCD register write arbiter: FSM states, sensor
// addressing defaults and the I2C transfer word layout.
package ccd_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HI_GO   = 3'd1,
        ST_HI_WAIT = 3'd2,
        ST_LO_GO   = 3'd3,
        ST_LO_WAIT = 3'd4,
        ST_GAP     = 3'd5,
        ST_REPORT  = 3'd6
    } ccdState_t;

    localparam logic [7:0] SLAVE_ADDR_DEFAULT = 8'hBA;
    localparam logic [7:0] LO_PREFIX_DEFAULT  = 8'hF1;

    function automatic logic [23:0] packI2cWord(
        input logic [7:0] slaveAddr,
        input logic [7:0] subAddr,
        input logic [7:0] dataByte
    );
        return {slaveAddr, subAddr, dataByte};
    endfunction

endpackage

// File: rtl/ccd_reg_write_arbiter_if.sv
// Requester bus and I2C controller handshake of the CCD register write arbiter.
interface ccd_reg_write_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    iREQ;
    logic [8*NUM_REQ-1:0]  iADDR;
    logic [16*NUM_REQ-1:0] iDATA;
    logic [NUM_REQ-1:0]    oDONE;
    logic                  oERR;
    logic                  oBUSY;
    logic [23:0]           oI2C_DATA;
    logic                  oI2C_GO;
    logic                  iI2C_END;
    logic                  iI2C_ACK;

    modport slave (
        input  iREQ, iADDR, iDATA, iI2C_END, iI2C_ACK,
        output oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO
    );

    modport master (
        output iREQ, iADDR, iDATA, iI2C_END, iI2C_ACK,
        input  oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO
    );
endinterface

// File: rtl/ccd_reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDXW-1:0]    rrPtr,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic [IDXW-1:0]    grantIdx,
    output logic               grantValid
);

    // Scan upward from the pointer, wrapping, and keep the first hit.
    always_comb begin
        int idx;
        grantOneHot = '0;
        grantIdx    = '0;
        grantValid  = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            if (!grantValid && reqVec[idx]) begin
                grantValid       = 1'b1;
                grantIdx         = IDXW'(idx);
                grantOneHot[idx] = 1'b1;
            end else begin
                grantValid = grantValid;
            end
        end
    end

endmodule

// File: rtl/ccd_reg_write_arbiter.sv
// Shares the sensor I2C write engine between requesters; each 16-bit register
// write becomes two transfers (addr+high byte, prefix+low byte) with retry.
module ccd_reg_write_arbiter
    import ccd_cfg_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
    parameter logic [7:0] LO_PREFIX  = LO_PREFIX_DEFAULT,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 4095
) (
    input logic                    iCLK,
    input logic                    iRST,
    ccd_reg_write_arbiter_if.slave bus
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_REQ - 1);
    localparam logic [TW-1:0]   TIMEOUT_V   = TW'(TIMEOUT);
    localparam logic [RW-1:0]   MAX_RETRY_V = RW'(MAX_RETRY);

    ccdState_t          state_r, nextState_s;
    logic [IDXW-1:0]    grantIdx_r, nextGrant_s;
    logic [IDXW-1:0]    ptr_r, nextPtr_s;
    logic [7:0]         addr_r, nextAddr_s;
    logic [15:0]        data_r, nextData_s;
    logic [RW-1:0]      retry_r, nextRetry_s;
    logic [TW-1:0]      timer_r, nextTimer_s;
    logic               loPhase_r, nextLo_s;
    logic               errFlag_r, nextErrFlag_s;
    logic               go_r, nextGo_s;
    logic [23:0]        i2cData_r, nextI2cData_s;
    logic [NUM_REQ-1:0] done_r, nextDone_s;
    logic               err_r, nextErr_s;
    logic               busy_r, nextBusy_s;
    logic               attemptFail_s;

    logic [NUM_REQ-1:0] arbOneHot_s;
    logic [IDXW-1:0]    arbIdx_s;
    logic               arbValid_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_arbiter (
        .reqVec      (bus.iREQ),
        .rrPtr       (ptr_r),
        .grantOneHot (arbOneHot_s),
        .grantIdx    (arbIdx_s),
        .grantValid  (arbValid_s)
    );

    // Next-state and next-output decode for the transfer sequencer.
    always_comb begin
        nextState_s   = state_r;
        nextGrant_s   = grantIdx_r;
        nextPtr_s     = ptr_r;
        nextAddr_s    = addr_r;
        nextData_s    = data_r;
        nextRetry_s   = retry_r;
        nextTimer_s   = timer_r;
        nextLo_s      = loPhase_r;
        nextErrFlag_s = errFlag_r;
        nextGo_s      = go_r;
        nextI2cData_s = i2cData_r;
        nextDone_s    = '0;
        nextErr_s     = 1'b0;
        nextBusy_s    = busy_r;
        attemptFail_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // The cycle showing oDONE is skipped so the finished requester can drop iREQ.
                if (arbValid_s && (done_r == '0) && (arbOneHot_s != '0)) begin
                    nextGrant_s   = arbIdx_s;
                    nextAddr_s    = bus.iADDR[int'(arbIdx_s) * 8 +: 8];
                    nextData_s    = bus.iDATA[int'(arbIdx_s) * 16 +: 16];
                    nextRetry_s   = '0;
                    nextErrFlag_s = 1'b0;
                    nextLo_s      = 1'b0;
                    nextBusy_s    = 1'b1;
                    nextState_s   = ST_HI_GO;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_HI_GO: begin
                nextI2cData_s = packI2cWord(SLAVE_ADDR, addr_r, data_r[15:8]);
                nextGo_s      = 1'b1;
                nextTimer_s   = '0;
                nextState_s   = ST_HI_WAIT;
            end
            ST_LO_GO: begin
                nextI2cData_s = packI2cWord(SLAVE_ADDR, LO_PREFIX, data_r[7:0]);
                nextGo_s      = 1'b1;
                nextTimer_s   = '0;
                nextState_s   = ST_LO_WAIT;
            end
            ST_HI_WAIT, ST_LO_WAIT: begin
                // END is checked before the timer so a last-cycle END still counts.
                if (bus.iI2C_END) begin
                    nextGo_s = 1'b0;
                    if (!bus.iI2C_ACK) begin
                        if (state_r == ST_HI_WAIT) begin
                            nextLo_s    = 1'b1;
                            nextState_s = ST_GAP;
                        end else begin
                            nextErrFlag_s = 1'b0;
                            nextState_s   = ST_REPORT;
                        end
                    end else begin
                        attemptFail_s = 1'b1;
                    end
                end else if (timer_r == TIMEOUT_V) begin
                    nextGo_s      = 1'b0;
                    attemptFail_s = 1'b1;
                end else begin
                    nextTimer_s = timer_r + 1'b1;
                end
            end
            ST_GAP: begin
                if (!bus.iI2C_END) begin
                    nextState_s = loPhase_r ? ST_LO_GO : ST_HI_GO;
                end else begin
                    nextState_s = ST_GAP;
                end
            end
            ST_REPORT: begin
                nextDone_s[grantIdx_r] = 1'b1;
                nextErr_s   = errFlag_r;
                nextPtr_s   = (grantIdx_r == LAST_IDX) ? '0 : (grantIdx_r + 1'b1);
                nextBusy_s  = 1'b0;
                nextState_s = ST_IDLE;
            end
            default: begin
                nextGo_s    = 1'b0;
                nextBusy_s  = 1'b0;
                nextState_s = ST_IDLE;
            end
        endcase

        // A failed attempt repeats the whole register write from the high byte.
        if (attemptFail_s) begin
            if (retry_r < MAX_RETRY_V) begin
                nextRetry_s = retry_r + 1'b1;
                nextLo_s    = 1'b0;
                nextState_s = ST_GAP;
            end else begin
                nextErrFlag_s = 1'b1;
                nextState_s   = ST_REPORT;
            end
        end else begin
            nextRetry_s = nextRetry_s;
        end
    end

    // State, context and registered outputs; reset aborts silently.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r    <= ST_IDLE;
            grantIdx_r <= '0;
            ptr_r      <= '0;
            addr_r     <= 8'h00;
            data_r     <= 16'h0000;
            retry_r    <= '0;
            timer_r    <= '0;
            loPhase_r  <= 1'b0;
            errFlag_r  <= 1'b0;
            go_r       <= 1'b0;
            i2cData_r  <= 24'h000000;
            done_r     <= '0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            grantIdx_r <= nextGrant_s;
            ptr_r      <= nextPtr_s;
            addr_r     <= nextAddr_s;
            data_r     <= nextData_s;
            retry_r    <= nextRetry_s;
            timer_r    <= nextTimer_s;
            loPhase_r  <= nextLo_s;
            errFlag_r  <= nextErrFlag_s;
            go_r       <= nextGo_s;
            i2cData_r  <= nextI2cData_s;
            done_r     <= nextDone_s;
            err_r      <= nextErr_s;
            busy_r     <= nextBusy_s;
        end
    end

    assign bus.oDONE     = done_r;
    assign bus.oERR      = err_r;
    assign bus.oBUSY     = busy_r;
    assign bus.oI2C_DATA = i2cData_r;
    assign bus.oI2C_GO   = go_r;

endmodule

// File: tb/tb_ccd_reg_write_arbiter.sv
// Scoreboard bench: stimulus queues expected I2C words and completions, a
// monitor pops them as the DUT presents transfers and oDONE pulses.
module tb_ccd_reg_write_arbiter;
    import ccd_cfg_pkg::*;

    localparam int NUM_REQ = 4;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    ccd_reg_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    ccd_reg_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SLAVE_ADDR (8'hBA),
        .LO_PREFIX  (8'hF1),
        .MAX_RETRY  (3),
        .TIMEOUT    (15)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    typedef struct {
        int   idx;
        logic err;
    } doneExp_t;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] expXfer[$];
    doneExp_t    expDone[$];

    // I2C controller model knobs
    int   nackHiLeft = 0;
    logic holdLoEnd  = 1'b0;
    int   endDelay   = 0;
    logic isHi;
    logic silent;
    logic nack;

    // Controller model: END 3 cycles after GO; sub 8'h55 always NACKs, sub 8'h77 never ends.
    always @(negedge iCLK) begin
        if (iRST || !bus.oI2C_GO) begin
            bus.iI2C_END = 1'b0;
            bus.iI2C_ACK = 1'b0;
            endDelay     = 0;
        end else if (!bus.iI2C_END) begin
            endDelay = endDelay + 1;
            isHi     = (bus.oI2C_DATA[15:8] != 8'hF1);
            silent   = (isHi && bus.oI2C_DATA[15:8] == 8'h77) || (!isHi && holdLoEnd);
            nack     = isHi && ((bus.oI2C_DATA[15:8] == 8'h55) || (nackHiLeft > 0));
            if (endDelay >= 3 && !silent) begin
                bus.iI2C_END = 1'b1;
                bus.iI2C_ACK = nack;
                if (nack && bus.oI2C_DATA[15:8] != 8'h55) nackHiLeft = nackHiLeft - 1;
            end
        end
    end

    logic        goPrev = 1'b0;
    logic [23:0] capData = 24'h0;
    logic        stable = 1'b1;
    logic [23:0] wantXfer;
    doneExp_t    wantDone;
    logic [NUM_REQ-1:0] wantOh;

    // Monitor: compares each GO rise and each oDONE pulse against the queues.
    always @(negedge iCLK) begin
        if (bus.oI2C_GO && !goPrev) begin
            capData = bus.oI2C_DATA;
            stable  = 1'b1;
            checks++;
            if (expXfer.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got %h want none", bus.oI2C_DATA);
            end else begin
                wantXfer = expXfer.pop_front();
                if (bus.oI2C_DATA !== wantXfer) begin
                    errors++;
                    $display("FAIL xfer got %h want %h", bus.oI2C_DATA, wantXfer);
                end
            end
        end else if (bus.oI2C_GO && (bus.oI2C_DATA !== capData)) begin
            stable = 1'b0;
        end
        if (!bus.oI2C_GO && goPrev) begin
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL xfer_stable word %h changed while GO high", capData);
            end
        end
        if (bus.oDONE !== '0) begin
            checks++;
            if (expDone.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got %b want none", bus.oDONE);
            end else begin
                wantDone = expDone.pop_front();
                wantOh = '0;
                wantOh[wantDone.idx] = 1'b1;
                if (bus.oDONE !== wantOh || bus.oERR !== wantDone.err) begin
                    errors++;
                    $display("FAIL done got %b err %b want %b err %b",
                             bus.oDONE, bus.oERR, wantOh, wantDone.err);
                end
            end
        end
        goPrev = bus.oI2C_GO;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic setReq(input int idx, input logic [7:0] addr, input logic [15:0] data);
        bus.iADDR[idx*8 +: 8]   = addr;
        bus.iDATA[idx*16 +: 16] = data;
    endtask

    task automatic pushWrite(input logic [7:0] addr, input logic [15:0] data,
                             input int hiCount, input bit withLo);
        for (int i = 0; i < hiCount; i++) expXfer.push_back({8'hBA, addr, data[15:8]});
        if (withLo) expXfer.push_back({8'hBA, 8'hF1, data[7:0]});
    endtask

    task automatic pushDone(input int idx, input logic err);
        doneExp_t d;
        d.idx = idx;
        d.err = err;
        expDone.push_back(d);
    endtask

    task automatic waitDones(input int n, input bit hold, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge iCLK);
            cyc++;
            if (bus.oDONE != '0) begin
                got++;
                if (!hold) bus.iREQ = bus.iREQ & ~bus.oDONE;
                else if (got == n) bus.iREQ = '0;
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL wait_done got %0d pulses want %0d", got, n);
        end
    endtask

    int cyc;
    int hiLen;

    initial begin
        bus.iREQ  = '0;
        bus.iADDR = '0;
        bus.iDATA = '0;

        // Reset state
        repeat (3) @(negedge iCLK);
        check("rst_go",   32'(bus.oI2C_GO),   32'd0);
        check("rst_busy", 32'(bus.oBUSY),     32'd0);
        check("rst_done", 32'(bus.oDONE),     32'd0);
        check("rst_err",  32'(bus.oERR),      32'd0);
        check("rst_data", 32'(bus.oI2C_DATA), 32'd0);
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);

        // Round-robin from pointer 0 with requesters 0,1,3 held
        setReq(0, 8'h10, 16'hA55A);
        setReq(1, 8'h20, 16'h1234);
        setReq(3, 8'h30, 16'hBEEF);
        pushWrite(8'h10, 16'hA55A, 1, 1'b1); pushDone(0, 1'b0);
        pushWrite(8'h20, 16'h1234, 1, 1'b1); pushDone(1, 1'b0);
        pushWrite(8'h30, 16'hBEEF, 1, 1'b1); pushDone(3, 1'b0);
        pushWrite(8'h10, 16'hA55A, 1, 1'b1); pushDone(0, 1'b0);
        bus.iREQ = 4'b1011;
        waitDones(4, 1'b1, 200);
        repeat (3) @(negedge iCLK);

        // Single write with GO latency
        setReq(0, 8'h09, 16'h0123);
        pushWrite(8'h09, 16'h0123, 1, 1'b1); pushDone(0, 1'b0);
        bus.iREQ = 4'b0001;
        @(negedge iCLK);
        check("lat_busy", 32'(bus.oBUSY),   32'd1);
        check("lat_go0",  32'(bus.oI2C_GO), 32'd0);
        @(negedge iCLK);
        check("lat_go1",  32'(bus.oI2C_GO), 32'd1);
        waitDones(1, 1'b0, 60);
        @(negedge iCLK);
        check("idle_busy", 32'(bus.oBUSY), 32'd0);
        repeat (2) @(negedge iCLK);

        // Two NACKed high bytes, then success
        nackHiLeft = 2;
        setReq(1, 8'h44, 16'h5678);
        pushWrite(8'h44, 16'h5678, 3, 1'b1); pushDone(1, 1'b0);
        bus.iREQ = 4'b0010;
        waitDones(1, 1'b0, 120);
        check("nack_left", 32'(nackHiLeft), 32'd0);
        repeat (3) @(negedge iCLK);

        // Abandon after MAX_RETRY+1 NACKs, next requester still served
        setReq(2, 8'h55, 16'h9ABC);
        setReq(3, 8'h66, 16'hDEF0);
        pushWrite(8'h55, 16'h9ABC, 4, 1'b0); pushDone(2, 1'b1);
        pushWrite(8'h66, 16'hDEF0, 1, 1'b1); pushDone(3, 1'b0);
        bus.iREQ = 4'b1100;
        waitDones(2, 1'b0, 200);
        repeat (3) @(negedge iCLK);

        // Timeout: END never returned, each attempt times out
        setReq(0, 8'h77, 16'h1234);
        pushWrite(8'h77, 16'h1234, 4, 1'b0); pushDone(0, 1'b1);
        bus.iREQ = 4'b0001;
        cyc = 0;
        while (!bus.oI2C_GO && cyc < 20) begin @(negedge iCLK); cyc++; end
        hiLen = 0;
        while (bus.oI2C_GO && hiLen < 40) begin @(negedge iCLK); hiLen++; end
        checks++;
        if (hiLen < 15 || hiLen > 16) begin
            errors++;
            $display("FAIL timeout_len got %0d cycles want 15..16", hiLen);
        end
        waitDones(1, 1'b0, 300);
        repeat (3) @(negedge iCLK);

        // Reset while waiting for the low-byte END
        holdLoEnd = 1'b1;
        setReq(1, 8'h88, 16'h4321);
        pushWrite(8'h88, 16'h4321, 1, 1'b1);
        bus.iREQ = 4'b0010;
        cyc = 0;
        while (!(bus.oI2C_GO && bus.oI2C_DATA[15:8] == 8'hF1) && cyc < 60) begin
            @(negedge iCLK);
            cyc++;
        end
        check("lo_wait_reached", 32'(bus.oI2C_DATA), 32'h00BAF121);
        repeat (2) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        check("rst_mid_go",   32'(bus.oI2C_GO), 32'd0);
        check("rst_mid_busy", 32'(bus.oBUSY),   32'd0);
        bus.iREQ = '0;
        @(negedge iCLK);
        iRST = 1'b0;
        holdLoEnd = 1'b0;
        repeat (20) @(negedge iCLK);

        check("xfer_queue_empty", 32'(expXfer.size()), 32'd0);
        check("done_queue_empty", 32'(expDone.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_reg_write_arbiter.md
# ccd_reg_write_arbiter

Shares the single I2C write engine that configures the CCD sensor between several requesters (startup LUT sequencer, exposure updater, per-channel gain updaters). Each requester asks for one 16-bit sensor register write. The block arbitrates round-robin and splits each write into the sensor's two-transfer format: register address plus high byte, then the low-byte prefix plus low byte. It drives the GO/END/ACK handshake of the existing I2C controller, retries NACKed writes, and reports completion or failure per requester.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- SLAVE_ADDR, 8'hBA: sensor I2C write address; bits [23:16] of every transfer.
- LO_PREFIX, 8'hF1: sub-address used for the low-byte transfer.
- MAX_RETRY, 3: extra attempts after a NACK before the write is abandoned.
- TIMEOUT, 4095: iCLK cycles to wait for iI2C_END before the attempt counts as failed.
- iCLK  in  1  clock; the same domain as the I2C controller work clock.
- iRST  in  1  asynchronous reset, active-high.
- iREQ  in  NUM_REQ  per-requester write request; a level signal.
- iADDR  in  8*NUM_REQ  register address; requester i uses [8i+7:8i].
- iDATA  in  16*NUM_REQ  register data; requester i uses [16i+15:16i].
- oDONE  out  NUM_REQ  one-cycle completion pulse for requester i.
- oERR  out  1  valid together with oDONE; 1 means the write was abandoned.
- oBUSY  out  1  high from grant until the oDONE pulse.
- oI2C_DATA  out  24  transfer word {SLAVE_ADDR, sub-address, byte}.
- oI2C_GO  out  1  start of transfer to the I2C controller.
- iI2C_END  in  1  transfer finished; a level signal from the controller.
- iI2C_ACK  in  1  sampled with END; 0 means acknowledged, 1 means NACK.

## Operation
- **States:** IDLE, HI_GO, HI_WAIT, LO_GO, LO_WAIT, GAP, REPORT.
- **IDLE:**
  - When any iREQ is high, grant the first requesting index at or after the round-robin pointer, wrapping past NUM_REQ-1.
  - Latch that requester's iADDR and iDATA, set oBUSY, and clear the retry count. Go to HI_GO.
- **HI_GO:** set oI2C_DATA = {SLAVE_ADDR, addr, data[15:8]} and oI2C_GO = 1. Go to HI_WAIT.
- **HI_WAIT:**
  - Hold GO until iI2C_END = 1.
  - On END, drop GO.
  - If ACK = 0, go to GAP and then LO_GO.
  - If ACK = 1, the attempt has failed.
- **LO_GO / LO_WAIT:** same as the high phase, with oI2C_DATA = {SLAVE_ADDR, LO_PREFIX, data[7:0]}. On an acknowledged END, go to REPORT with the error flag cleared.
- **GAP:** wait until iI2C_END = 0 before entering the next *_GO state. This guarantees a full GO low/high edge per transfer.
- **Failed attempt** (NACK, or timeout counter reaching TIMEOUT in either *_WAIT state):
  - If retry count < MAX_RETRY: increment it, drop GO, and restart from the HI phase through GAP. The whole register write is repeated.
  - Otherwise go to REPORT with the error flag set.
- **REPORT:**
  - Pulse oDONE[grant] for one cycle and drive oERR from the error flag.
  - Set the pointer to grant+1 (mod NUM_REQ) and clear oBUSY. Return to IDLE.
- **Requester rules:**
  - Changes to iADDR/iDATA after the grant are ignored.
  - A requester must drop iREQ in the cycle after its oDONE, otherwise it is granted again.
  - Deasserting iREQ mid-write does not abort the write.
- **Timeout counter:** cleared on every entry into a *_WAIT state and saturates at TIMEOUT.

## Timing
- **Reset values:** all outputs 0, state IDLE, pointer 0, counters 0. Reset mid-transfer drops GO immediately and aborts silently, with no oDONE.
- **GO latency:**
  - oI2C_GO rises 2 cycles after iREQ is sampled high in IDLE: grant, then HI_GO.
  - oI2C_DATA is stable from GO rise until END is seen.
- **Minimum gaps:**
  - GO falls in the cycle after END is sampled.
  - GO is low for ≥ 1 cycle between transfers.
  - Minimum of 2 cycles from the low-byte END to the oDONE pulse.
- **Simultaneous requests:** resolved only in IDLE. With the pointer at p, the order is p, p+1, …. No requester waits more than NUM_REQ-1 writes.
- **Timeout:** an END arriving in the same cycle the counter hits TIMEOUT is honoured as a real END.

## Structure
- The shared package (ccd_cfg_pkg) holds:
  - the state enum;
  - constants SLAVE_ADDR_DEFAULT = 8'hBA and LO_PREFIX_DEFAULT = 8'hF1;
  - an I2C word packing function {slave, sub, byte}.
- One sub-module is natural: rr_arbiter.
  - Parameterised by NUM_REQ.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index and a valid flag. Purely combinational.

## Test plan
- **Single write:** iREQ[0] = 1, addr 8'h09, data 16'h0123, model always ACKs.
  - Expect transfers 24'hBA0901 then 24'hBAF123.
  - Expect one oDONE[0] pulse with oERR = 0.
- **Round-robin:** iREQ = 4'b1011 held, pointer 0.
  - Grant order 0, 1, 3, 0.
  - Each write is two transfers; no GO overlap.
- **NACK retry:** model NACKs the first two high-byte transfers, MAX_RETRY = 3.
  - Expect 3 high-byte transfers, then the low byte.
  - Expect oDONE with oERR = 0.
- **Abandon:** model NACKs always.
  - Expect exactly MAX_RETRY+1 high-byte attempts, then oDONE with oERR = 1.
  - The next requester is then served.
- **Timeout and reset:**
  - END is never returned, TIMEOUT = 15: the attempt fails after 15 cycles and is retried.
  - Assert iRST mid-LO_WAIT: GO and oBUSY are 0 the same cycle, and no oDONE is pulsed.
